// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// wait-counter sizing, memory timeout default and the load-use test.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_MDU_WAIT = 2'b10,
    ST_FAULT    = 2'b11
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  // Wide enough for the largest allowed timeout (255).
  localparam int WAIT_W = 8;

  // A load in EX whose destination feeds an ID source operand; x0 never hazards.
  function automatic logic load_use_hit(input logic       memrd,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return memrd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count up on each inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multicycle
// MDU waits and data-memory waits with a timeout that latches a fault.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRd_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             NextPCSrc_ex,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  input  logic             MemAcc_me,
  input  logic             dmem_ready,
  output logic             PCWr,
  output logic             IFIDWr,
  output logic             IDEXWr,
  output logic             EXMEWr,
  output logic             IFIDClr,
  output logic             IDEXClr,
  output logic             EXMEClr,
  output logic             MEWBClr,
  output logic [1:0]       state_o,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_e            r_state;
  state_e            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_mem_err;
  logic              w_err_set;
  logic              w_load_use;
  logic              w_run_rules;
  logic              w_hazard_rules;
  logic              w_mem_stall;
  logic              w_mdu_stall;
  logic              w_fault;

  assign w_load_use = load_use_hit(MemRd_ex, rd_ex, rs1_id, rs2_id);

  // Next state and stage controls; the highest-priority active condition wins.
  always_comb begin
    PCWr           = 1'b1;
    IFIDWr         = 1'b1;
    IDEXWr         = 1'b1;
    EXMEWr         = 1'b1;
    IFIDClr        = 1'b0;
    IDEXClr        = 1'b0;
    EXMEClr        = 1'b0;
    MEWBClr        = 1'b0;
    w_state_next   = r_state;
    w_wait_next    = r_wait_cnt;
    w_err_set      = 1'b0;
    w_run_rules    = 1'b0;
    w_hazard_rules = 1'b0;
    w_mem_stall    = 1'b0;
    w_mdu_stall    = 1'b0;
    w_fault        = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (MemAcc_me && !dmem_ready) begin
          w_mem_stall  = 1'b1;
          w_state_next = ST_MEM_WAIT;
          w_wait_next  = WAIT_W'(1);
        end else begin
          w_run_rules = 1'b1;
          w_wait_next = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt == TIMEOUT_CNT) begin
            w_state_next = ST_FAULT;
            w_err_set    = 1'b1;
          end else begin
            w_wait_next = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          // Memory has answered: fall back to the ordinary RUN decisions.
          w_run_rules  = 1'b1;
          w_state_next = ST_RUN;
          w_wait_next  = '0;
        end
      end
      ST_MDU_WAIT: begin
        if (!mdu_done) begin
          w_mdu_stall = 1'b1;
        end else begin
          // Result is back; a new mdu_start in EX is not re-launched here.
          w_hazard_rules = 1'b1;
          w_state_next   = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    if (w_run_rules) begin
      if (mdu_start_ex) begin
        w_mdu_stall  = 1'b1;
        w_state_next = ST_MDU_WAIT;
      end else begin
        w_hazard_rules = 1'b1;
      end
    end

    if (w_mem_stall) begin
      PCWr    = 1'b0;
      IFIDWr  = 1'b0;
      IDEXWr  = 1'b0;
      EXMEWr  = 1'b0;
      MEWBClr = 1'b1;
    end

    if (w_mdu_stall) begin
      PCWr    = 1'b0;
      IFIDWr  = 1'b0;
      IDEXWr  = 1'b0;
      EXMEClr = 1'b1;
    end

    // A taken branch flushes the younger instructions, so a load-use on
    // one of them is moot.
    if (w_hazard_rules) begin
      if (NextPCSrc_ex) begin
        IFIDClr = 1'b1;
        IDEXClr = 1'b1;
      end else if (w_load_use) begin
        PCWr    = 1'b0;
        IFIDWr  = 1'b0;
        IDEXClr = 1'b1;
      end
    end

    if (w_fault) begin
      PCWr    = 1'b0;
      IFIDWr  = 1'b0;
      IDEXWr  = 1'b0;
      EXMEWr  = 1'b0;
      IFIDClr = 1'b1;
      IDEXClr = 1'b1;
      EXMEClr = 1'b1;
      MEWBClr = 1'b1;
    end

    // While reset is held the pipeline sees plain RUN defaults, even from FAULT.
    if (!rst_n) begin
      PCWr    = 1'b1;
      IFIDWr  = 1'b1;
      IDEXWr  = 1'b1;
      EXMEWr  = 1'b1;
      IFIDClr = 1'b0;
      IDEXClr = 1'b0;
      EXMEClr = 1'b0;
      MEWBClr = 1'b0;
    end
  end

  // State, memory-wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign state_o = r_state;
  assign mem_err = r_mem_err;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr_n (rst_n),
    .i_inc   (!PCWr),
    .o_count (stall_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max memory-wait cycles before fault (1..255).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  in  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port MemRd_ex  in  1  load in EX.
REQ-006 SHALL have port rd_ex  in  5  EX destination register.
REQ-007 SHALL have ports rs1_id, rs2_id  in  5 each  ID source registers.
REQ-008 SHALL have port NextPCSrc_ex  in  1  branch/jump taken in EX.
REQ-009 SHALL have port mdu_start_ex  in  1  multicycle mul/div instruction in EX.
REQ-010 SHALL have port mdu_done  in  1  MDU result valid this cycle.
REQ-011 SHALL have ports MemAcc_me, dmem_ready  in  1 each  ME data-memory access, memory ready.
REQ-012 SHALL have ports PCWr, IFIDWr, IDEXWr, EXMEWr  out  1 each  stage register write enables (1 = advance).
REQ-013 SHALL have ports IFIDClr, IDEXClr, EXMEClr, MEWBClr  out  1 each  stage register bubble insert.
REQ-014 SHALL have ports state_o  out  2  current FSM state; mem_err  out  1  sticky timeout flag; stall_cnt  out  CNT_W  stall-cycle count.

Function
REQ-015 SHALL implement FSM states RUN(00), MEM_WAIT(01), MDU_WAIT(10), FAULT(11); control outputs combinational from state and inputs.
REQ-016 Default outputs SHALL be all Wr=1, all Clr=0.
REQ-017 Load-use: MemRd_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id) SHALL give PCWr=0, IFIDWr=0, IDEXClr=1.
REQ-018 In RUN, priority SHALL be memory wait > MDU start > branch > load-use; only the highest active condition applies.
REQ-019 RUN, MemAcc_me && !dmem_ready: all Wr=0, MEWBClr=1, next MEM_WAIT, wait counter loaded 1.
REQ-020 RUN, mdu_start_ex: PCWr=IFIDWr=IDEXWr=0, EXMEClr=1, next MDU_WAIT.
REQ-021 RUN, NextPCSrc_ex: IFIDClr=1, IDEXClr=1, all Wr=1; load-use ignored that cycle.
REQ-022 MEM_WAIT, !dmem_ready: all Wr=0, MEWBClr=1, counter +1; counter==TIMEOUT SHALL set mem_err, next FAULT.
REQ-023 MEM_WAIT, dmem_ready: outputs per RUN rules with memory condition satisfied, next state per those rules, RUN if none.
REQ-024 MDU_WAIT, !mdu_done: PCWr=IFIDWr=IDEXWr=0, EXMEClr=1; MemAcc_me ignored.
REQ-025 MDU_WAIT, mdu_done: EXMEWr=1, EXMEClr=0; branch/load-use per RUN rules, mdu_start_ex ignored; next RUN.
REQ-026 FAULT: all Wr=0, all Clr=1, stays until reset.
REQ-027 stall_cnt SHALL increment each cycle PCWr==0, saturating at 2^CNT_W-1.
REQ-028 Latency: stall/flush controls SHALL act in the same cycle as the triggering input; no pipelining.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state RUN, wait counter 0, mem_err=0, stall_cnt=0; applies mid-wait, including FAULT.
REQ-030 During reset, outputs SHALL be defaults of RUN with all inputs low.

Structure
REQ-031 State enum, its encodings and TIMEOUT default SHALL live in shared package pipe_ctrl_pkg.
REQ-032 stall_cnt SHALL be a sub-module sat_counter (parameter width, inc, sync active-low clear).

Verification
REQ-033 Load x5 in EX, ID rs1=5 -> one cycle PCWr=0, IFIDWr=0, IDEXClr=1; rd_ex=0 -> no stall.
REQ-034 NextPCSrc_ex=1 with simultaneous load-use -> IFIDClr=IDEXClr=1, PCWr=1, stall_cnt unchanged.
REQ-035 MemAcc_me=1, dmem_ready low 3 cycles -> state 01 for 3 cycles, all Wr=0, stall_cnt=3, then RUN.
REQ-036 mdu_start_ex, mdu_done after 4 cycles -> EXMEClr=1 for 4 cycles, EXMEWr=1 on done, back RUN.
REQ-037 TIMEOUT=4, dmem_ready never -> mem_err=1, state 11; rst_n=0 one edge -> state 00, mem_err=0, stall_cnt=0.
REQ-038 CNT_W=4, 20 stalled cycles -> stall_cnt holds 15.
